// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the timed intersection controller:
//   - lamp codes driven on the 2-bit lamp outputs
//   - state encodings; the numeric values are visible on the debug state port
//   - widths of the lamp and state buses
// -----------------------------------------------------------------------------
package traffic_pkg;

  localparam int LIGHT_W = 2;
  localparam int STATE_W = 3;

  typedef enum logic [LIGHT_W-1:0] {
    L_RED    = 2'd0,
    L_GREEN  = 2'd1,
    L_YELLOW = 2'd2,
    L_OFF    = 2'd3
  } light_t;

  // S_ILLEGAL is listed so that every 3-bit code has a name; the FSM never
  // enters it on purpose and leaves it for S_HG on the next edge.
  typedef enum logic [STATE_W-1:0] {
    S_HG      = 3'd0,  // highway green
    S_HY      = 3'd1,  // highway yellow
    S_AR1     = 3'd2,  // all red, highway -> country
    S_CG      = 3'd3,  // country green (pedestrians walk)
    S_CY      = 3'd4,  // country yellow
    S_AR2     = 3'd5,  // all red, country -> highway
    S_FLASH   = 3'd6,  // night flashing
    S_ILLEGAL = 3'd7
  } state_t;

endpackage

// File: rtl/traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// traffic_phase_timer
// Counts cycles spent in the current controller state. The count restarts at
// zero on the cycle the controller changes state and otherwise increments,
// holding at the all-ones value instead of wrapping so that long residencies
// (e.g. an idle highway green) never look like a fresh phase.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset, forces cnt to 0
//   clear  in   state is changing on this edge, so cnt restarts at 0
//   cnt    out  CNT_W-bit saturating phase count
// -----------------------------------------------------------------------------
module traffic_phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_ctrl_timed.sv
// -----------------------------------------------------------------------------
// traffic_ctrl_timed
// Highway / country-road intersection controller. The highway rests on green;
// a waiting country vehicle or pedestrian is latched and served after the
// highway minimum green, through yellow and an all-red clearance. Country
// green ends once its minimum has elapsed and no vehicle is present, or at a
// hard maximum so the highway cannot be starved. Night mode is only entered
// from highway green and flashes the lamps until released, leaving through
// the highway-bound all-red clearance.
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   ct_sensor   in   country-road vehicle present
//   ped_req     in   pedestrian request (pulse or level)
//   night_mode  in   night flashing request
//   hwy_light   out  highway lamp (RED/GREEN/YELLOW/OFF)
//   ct_light    out  country lamp (same encoding)
//   ped_walk    out  walk lamp, lit only during country green
//   state_o     out  current FSM state, debug
//
// All outputs are decoded from registers only; inputs reach them solely
// through the next-state logic.
// -----------------------------------------------------------------------------
module traffic_ctrl_timed
  import traffic_pkg::*;
#(
  parameter int CNT_W         = 5,
  parameter int HWY_MIN_GREEN = 8,
  parameter int YELLOW_CYC    = 3,
  parameter int ALLRED_CYC    = 2,
  parameter int CT_MIN_GREEN  = 4,
  parameter int CT_MAX_GREEN  = 12,
  parameter int FLASH_HALF    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ct_sensor,
  input  logic               ped_req,
  input  logic               night_mode,
  output logic [LIGHT_W-1:0] hwy_light,
  output logic [LIGHT_W-1:0] ct_light,
  output logic               ped_walk,
  output logic [STATE_W-1:0] state_o
);

  // Last cycle index of each timed phase. A phase of N cycles occupies
  // cnt = 0 .. N-1, so the exit decision is taken when cnt reaches N-1.
  localparam logic [CNT_W-1:0] HWY_LAST    = CNT_W'(HWY_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] CT_MIN_LAST = CNT_W'(CT_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] CT_MAX_LAST = CNT_W'(CT_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic             state_change;

  logic             ct_req;     // latched country vehicle request
  logic             ped_pend;   // latched pedestrian request
  logic             serve_edge; // AR1 -> CG: pending requests are being served

  logic             flash_on;   // 1: YELLOW/RED half, 0: OFF/OFF half
  logic [CNT_W-1:0] flash_cnt;

  // ---------------------------------------------------------------------------
  // Phase timer
  // ---------------------------------------------------------------------------
  assign state_change = (state_d != state_q);

  traffic_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state_change),
    .cnt   (cnt)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HG;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // Requests are looked at only in highway green; the raw inputs are ORed in
  // so a request arriving on the very cycle the minimum green expires is not
  // delayed by the latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HG: begin
        if (night_mode) begin
          state_d = S_FLASH;
        end else if ((cnt >= HWY_LAST) &&
                     (ct_req || ct_sensor || ped_pend || ped_req)) begin
          state_d = S_HY;
        end
      end
      S_HY: begin
        if (cnt == YELLOW_LAST) state_d = S_AR1;
      end
      S_AR1: begin
        if (cnt == ALLRED_LAST) state_d = S_CG;
      end
      S_CG: begin
        if (((cnt >= CT_MIN_LAST) && !ct_sensor) || (cnt == CT_MAX_LAST)) begin
          state_d = S_CY;
        end
      end
      S_CY: begin
        if (cnt == YELLOW_LAST) state_d = S_AR2;
      end
      S_AR2: begin
        if (cnt == ALLRED_LAST) state_d = S_HG;
      end
      S_FLASH: begin
        if (!night_mode) state_d = S_AR2;
      end
      default: begin
        state_d = S_HG;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latches
  // Cleared on the edge that starts country green; a request seen on that same
  // edge is dropped because the green being started serves it.
  // ---------------------------------------------------------------------------
  assign serve_edge = (state_q == S_AR1) && (state_d == S_CG);

  always_ff @(posedge clk) begin
    if (reset) begin
      ct_req   <= 1'b0;
      ped_pend <= 1'b0;
    end else if (serve_edge) begin
      ct_req   <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      ct_req   <= ct_req   | ct_sensor;
      ped_pend <= ped_pend | ped_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Flash phase generator
  // Held at the "on" phase outside FLASH so that every FLASH entry starts with
  // the lamps lit; inside FLASH it toggles every FLASH_HALF cycles. A separate
  // counter is used because the phase timer saturates.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      flash_on  <= 1'b1;
      flash_cnt <= '0;
    end else if (state_q != S_FLASH) begin
      flash_on  <= 1'b1;
      flash_cnt <= '0;
    end else if (flash_cnt == FLASH_LAST) begin
      flash_on  <= ~flash_on;
      flash_cnt <= '0;
    end else begin
      flash_cnt <= flash_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (Moore)
  // ---------------------------------------------------------------------------
  light_t hwy_l;
  light_t ct_l;

  always_comb begin
    hwy_l    = L_RED;
    ct_l     = L_RED;
    ped_walk = 1'b0;
    case (state_q)
      S_HG: begin
        hwy_l = L_GREEN;
        ct_l  = L_RED;
      end
      S_HY: begin
        hwy_l = L_YELLOW;
        ct_l  = L_RED;
      end
      S_CG: begin
        hwy_l    = L_RED;
        ct_l     = L_GREEN;
        ped_walk = 1'b1;
      end
      S_CY: begin
        hwy_l = L_RED;
        ct_l  = L_YELLOW;
      end
      S_FLASH: begin
        hwy_l = flash_on ? L_YELLOW : L_OFF;
        ct_l  = flash_on ? L_RED    : L_OFF;
      end
      default: begin
        // AR1, AR2 and the illegal code show all red.
        hwy_l = L_RED;
        ct_l  = L_RED;
      end
    endcase
  end

  assign hwy_light = hwy_l;
  assign ct_light  = ct_l;
  assign state_o   = state_q;

endmodule
